// File: rtl/crossbar_pkg.sv
// Shared types for the trigger crossbar: output modes, select-width derivation
// and the per-channel configuration record.
package crossbar_pkg;

    localparam int NUM_IN_DEF       = 12;
    localparam int NUM_OUT_DEF      = 12;
    localparam int STRETCH_BITS_DEF = 16;

    // One extra bit beyond the index width leaves a whole code space for "no source".
    function automatic int sel_bits_f(input int num_in);
        return $clog2(num_in) + 1;
    endfunction

    localparam int SEL_BITS_DEF = sel_bits_f(NUM_IN_DEF);

    typedef enum logic [1:0] {
        MODE_PASS       = 2'd0,
        MODE_INVERT     = 2'd1,
        MODE_RISE_PULSE = 2'd2,
        MODE_FALL_PULSE = 2'd3
    } mode_e;

    // Field widths follow the package defaults, which the engine's parameters default to.
    typedef struct packed {
        logic [SEL_BITS_DEF-1:0]     sel;
        mode_e                       mode;
        logic [STRETCH_BITS_DEF-1:0] stretch;
    } chan_cfg_t;

endpackage

// File: rtl/trigger_pulse_stretcher.sv
// One crossbar output: edge detect against the previous source sample, a
// saturating stretch counter and the registered output.
module trigger_pulse_stretcher
    import crossbar_pkg::*;
#(
    parameter int STRETCH_BITS = STRETCH_BITS_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    src_i,
    input  logic                    clear_i,
    input  mode_e                   mode_i,
    input  logic [STRETCH_BITS-1:0] stretch_i,
    output logic                    trig_o
);

    logic [STRETCH_BITS-1:0] cnt_q, cnt_d, len;
    logic                    prev_q, prev_d;
    logic                    out_q, out_d;
    logic                    hit;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        cnt_d  = cnt_q;
        prev_d = src_i;
        out_d  = 1'b0;
        hit    = 1'b0;
        len    = (stretch_i == '0) ? STRETCH_BITS'(1) : stretch_i;

        case (mode_i)
            MODE_PASS:       out_d = src_i;
            MODE_INVERT:     out_d = ~src_i;
            MODE_RISE_PULSE: hit   = src_i & ~prev_q;
            MODE_FALL_PULSE: hit   = ~src_i & prev_q;
            default:         out_d = 1'b0;
        endcase

        // A commit drops any pulse in flight; prev still tracks the new source, so no edge is seen.
        if (clear_i) begin
            cnt_d = '0;
        end else if (hit) begin
            cnt_d = len - STRETCH_BITS'(1);
            out_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - STRETCH_BITS'(1);
            out_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            cnt_q  <= '0;
            prev_q <= 1'b0;
            out_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            prev_q <= prev_d;
            out_q  <= out_d;
        end
    end

    assign trig_o = out_q;

endmodule

// File: rtl/trigger_crossbar_engine.sv
// Trigger crossbar: synchronises the inputs and routes any input to any output
// through shadow/active configuration with an atomic commit.
module trigger_crossbar_engine
    import crossbar_pkg::*;
#(
    parameter int NUM_IN       = NUM_IN_DEF,
    parameter int NUM_OUT      = NUM_OUT_DEF,
    parameter int STRETCH_BITS = STRETCH_BITS_DEF,
    parameter int SEL_BITS     = sel_bits_f(NUM_IN)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_IN-1:0]          trig_in,
    input  logic                       cfg_wr_en,
    input  logic [$clog2(NUM_OUT)-1:0] cfg_chan,
    input  logic [SEL_BITS-1:0]        cfg_sel,
    input  logic [1:0]                 cfg_mode,
    input  logic [STRETCH_BITS-1:0]    cfg_stretch,
    input  logic                       cfg_commit,
    output logic                       cfg_done,
    output logic                       cfg_err,
    output logic [NUM_OUT-1:0]         trig_out
);

    localparam int SRC_W = 2 ** SEL_BITS;

    logic [NUM_IN-1:0] sync1_q, sync2_q;
    logic [SRC_W-1:0]  src_vec;
    chan_cfg_t         shadow_q [NUM_OUT];
    chan_cfg_t         shadow_d [NUM_OUT];
    chan_cfg_t         active_q [NUM_OUT];
    chan_cfg_t         active_d [NUM_OUT];
    logic              commit_q, err_q, wr_ok;

    function automatic chan_cfg_t identity_cfg(input int chan);
        chan_cfg_t c;
        c.sel     = (chan < NUM_IN) ? SEL_BITS_DEF'(chan) : SEL_BITS_DEF'(NUM_IN);
        c.mode    = MODE_PASS;
        c.stretch = '0;
        return c;
    endfunction

    assign wr_ok = cfg_wr_en && (int'(cfg_chan) < NUM_OUT);

    // Zero-extending the synchronised inputs makes every out-of-range select read constant 0.
    assign src_vec = SRC_W'(sync2_q);

    always_comb begin
        shadow_d = shadow_q;
        if (wr_ok) begin
            shadow_d[cfg_chan] = '{sel: cfg_sel, mode: mode_e'(cfg_mode), stretch: cfg_stretch};
        end
        // Commit takes the post-write shadow, so a same-cycle write is included.
        active_d = active_q;
        if (cfg_commit) begin
            active_d = shadow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
            // NOTE: the configuration arrays are reset because identity routing must hold from the first cycle.
            for (int i = 0; i < NUM_OUT; i++) begin
                shadow_q[i] <= identity_cfg(i);
                active_q[i] <= identity_cfg(i);
            end
        end else begin
            sync1_q  <= trig_in;
            sync2_q  <= sync1_q;
            commit_q <= cfg_commit;
            err_q    <= cfg_wr_en && !wr_ok;
            for (int i = 0; i < NUM_OUT; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    // The stretchers see the new configuration together with the clear, one edge after commit.
    for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
        trigger_pulse_stretcher #(
            .STRETCH_BITS(STRETCH_BITS)
        ) u_stretch (
            .clk      (clk),
            .rst      (rst),
            .src_i    (src_vec[active_q[o].sel]),
            .clear_i  (commit_q),
            .mode_i   (active_q[o].mode),
            .stretch_i(active_q[o].stretch),
            .trig_o   (trig_out[o])
        );
    end

    assign cfg_done = commit_q;
    assign cfg_err  = err_q;

endmodule

// File: tb/tb_trigger_crossbar_engine.sv
// Directed bench for trigger_crossbar_engine: latency, pulse modes, shadow/commit,
// out-of-range handling and reset abort, all against hand-computed values.
module tb_trigger_crossbar_engine;
    import crossbar_pkg::*;

    localparam int NUM_IN       = 12;
    localparam int NUM_OUT      = 12;
    localparam int STRETCH_BITS = 16;
    localparam int SEL_BITS     = 5;
    localparam int CHAN_BITS    = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_IN-1:0]       trig_in;
    logic                    cfg_wr_en;
    logic [CHAN_BITS-1:0]    cfg_chan;
    logic [SEL_BITS-1:0]     cfg_sel;
    logic [1:0]              cfg_mode;
    logic [STRETCH_BITS-1:0] cfg_stretch;
    logic                    cfg_commit;
    logic                    cfg_done;
    logic                    cfg_err;
    logic [NUM_OUT-1:0]      trig_out;

    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    logic [31:0] hist;
    logic        seen;

    trigger_crossbar_engine #(
        .NUM_IN      (NUM_IN),
        .NUM_OUT     (NUM_OUT),
        .STRETCH_BITS(STRETCH_BITS),
        .SEL_BITS    (SEL_BITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trig_in    (trig_in),
        .cfg_wr_en  (cfg_wr_en),
        .cfg_chan   (cfg_chan),
        .cfg_sel    (cfg_sel),
        .cfg_mode   (cfg_mode),
        .cfg_stretch(cfg_stretch),
        .cfg_commit (cfg_commit),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .trig_out   (trig_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (cfg_done === 1'b1) done_cnt++;
    endtask

    task automatic cfg_write(input int chan, input int sel, input int mode, input int stretch,
                             input logic commit);
        cfg_wr_en   = 1'b1;
        cfg_chan    = CHAN_BITS'(chan);
        cfg_sel     = SEL_BITS'(sel);
        cfg_mode    = 2'(mode);
        cfg_stretch = STRETCH_BITS'(stretch);
        cfg_commit  = commit;
        step();
        cfg_wr_en   = 1'b0;
        cfg_commit  = 1'b0;
    endtask

    // Drive trig_in[5] with pat[n] after edge n; hist[n] records trig_out[0] after edge n.
    task automatic measure(input logic [31:0] pat, output logic [31:0] h);
        h = '0;
        trig_in[5] = pat[0];
        for (int n = 1; n < 32; n++) begin
            step();
            h[n] = trig_out[0];
            trig_in[5] = pat[n];
        end
    endtask

    initial begin
        rst         = 1'b1;
        trig_in     = '0;
        cfg_wr_en   = 1'b0;
        cfg_chan    = '0;
        cfg_sel     = '0;
        cfg_mode    = '0;
        cfg_stretch = '0;
        cfg_commit  = 1'b0;

        repeat (3) step();
        check("reset_trig_out", 32'(trig_out), 32'h0);
        check("reset_done", 32'(cfg_done), 32'h0);
        check("reset_err", 32'(cfg_err), 32'h0);
        rst = 1'b0;
        step();

        // Identity PASS latency on input 3
        trig_in[3] = 1'b1;
        step();
        step();
        check("pass_lat_edge2", 32'(trig_out), 32'h0);
        step();
        check("pass_lat_edge3", 32'(trig_out), 32'h008);
        trig_in[3] = 1'b0;
        repeat (3) step();
        check("pass_fall", 32'(trig_out), 32'h0);

        // Rise pulse, stretch 4, 20-clock input pulse
        done_cnt = 0;
        cfg_write(0, 5, MODE_RISE_PULSE, 4, 1'b0);
        check("write_no_done", 32'(cfg_done), 32'h0);
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        check("commit_done", 32'(cfg_done), 32'h1);
        measure(32'h000F_FFFF, hist);
        check("rise_stretch4", hist, 32'h0000_0078);
        check("done_once", 32'(done_cnt), 32'd1);

        // Retrigger every 2 clocks extends the pulse to 4 clocks after the last edge
        measure(32'h0000_0015, hist);
        check("rise_retrigger", hist, 32'h0000_07F8);

        // stretch 0 behaves as 1; write+commit in the same cycle
        cfg_write(0, 5, MODE_RISE_PULSE, 0, 1'b1);
        check("bypass_done", 32'(cfg_done), 32'h1);
        measure(32'h0000_0015, hist);
        check("rise_stretch0", hist, 32'h0000_00A8);

        // Fall pulse, stretch 2
        cfg_write(0, 5, MODE_FALL_PULSE, 2, 1'b1);
        measure(32'h0000_00FF, hist);
        check("fall_stretch2", hist, 32'h0000_1800);

        // Invert takes effect at the first edge after commit
        cfg_write(0, 5, MODE_INVERT, 0, 1'b1);
        check("invert_at_commit", 32'(trig_out[0]), 32'h0);
        step();
        check("invert_after_commit", 32'(trig_out[0]), 32'h1);
        trig_in[5] = 1'b1;
        repeat (3) step();
        check("invert_high_in", 32'(trig_out[0]), 32'h0);
        trig_in[5] = 1'b0;
        repeat (3) step();

        // Shadow write without commit leaves routing alone
        cfg_write(2, 1, MODE_PASS, 0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            trig_in[1] = ~trig_in[1];
            step();
            seen = seen | trig_out[2];
        end
        check("shadow_no_effect", 32'(seen), 32'h0);
        trig_in[2] = 1'b1;
        repeat (3) step();
        check("shadow_follow_in2", 32'(trig_out[2]), 32'h1);
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        check("sel_old_at_commit", 32'(trig_out[2]), 32'h1);
        step();
        check("sel_new_after_commit", 32'(trig_out[2]), 32'h0);
        trig_in[1] = 1'b1;
        repeat (3) step();
        check("sel_follow_in1", 32'(trig_out[2]), 32'h1);
        trig_in[1] = 1'b0;
        trig_in[2] = 1'b0;
        repeat (3) step();

        // Out-of-range channel with commit; out-of-range select
        cfg_write(NUM_OUT, 0, MODE_PASS, 0, 1'b1);
        check("chan_oor_err", 32'(cfg_err), 32'h1);
        check("chan_oor_commit_done", 32'(cfg_done), 32'h1);
        step();
        check("err_one_cycle", 32'(cfg_err), 32'h0);
        cfg_write(3, NUM_IN, MODE_PASS, 0, 1'b1);
        trig_in[3] = 1'b1;
        repeat (4) step();
        check("sel_oor_zero", 32'(trig_out), 32'h001);

        // Re-commit with no writes cancels a pulse in flight
        cfg_write(0, 5, MODE_RISE_PULSE, 100, 1'b1);
        step();
        trig_in[5] = 1'b1;
        repeat (10) step();
        check("long_pulse_high", 32'(trig_out[0]), 32'h1);
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        check("recommit_edge_high", 32'(trig_out[0]), 32'h1);
        check("recommit_done", 32'(cfg_done), 32'h1);
        step();
        check("recommit_cancel", 32'(trig_out[0]), 32'h0);
        repeat (3) step();
        check("recommit_no_edge", 32'(trig_out[0]), 32'h0);

        // Reset during a pulse and a commit
        trig_in[5] = 1'b0;
        repeat (4) step();
        trig_in[5] = 1'b1;
        repeat (10) step();
        check("pulse_before_rst", 32'(trig_out[0]), 32'h1);
        rst        = 1'b1;
        cfg_commit = 1'b1;
        step();
        check("rst_trig_out", 32'(trig_out), 32'h0);
        check("rst_done", 32'(cfg_done), 32'h0);
        rst        = 1'b0;
        cfg_commit = 1'b0;
        step();
        check("rst_commit_aborted", 32'(cfg_done), 32'h0);
        check("rst_sync_cleared", 32'(trig_out), 32'h0);
        repeat (2) step();
        check("rst_identity_pass", 32'(trig_out), 32'h028);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
